fifo_uart_tx: RTL and testbench

Serial transmit stage that drains the write-side FIFO. When the FIFO reports non-empty, it issues a one-cycle read strobe and captures the byte. It then shifts the byte out LSB-first as an asynchronous frame: 1 start bit, WIDTH data bits, an optional parity bit and 1 stop bit. It connects directly to the FIFO read port (read enable out; data and empty flag in) and drives the board TX pin.

---
 rtl/fifo_uart_tx.sv | 164 ++++++++++++++++
 tb/tb_fifo_uart_tx.sv | 206 ++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// ============================================================================
// Module   : fifo_uart_tx
// Purpose  : Drains a FIFO read port one byte at a time and shifts each byte
//            out LSB-first as an asynchronous serial frame: start bit, WIDTH
//            data bits, optional even-parity bit and one stop bit.
// Options  : define UART_TX_PARITY_EN to insert the even-parity bit.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_uart_tx #(
    parameter int WIDTH        = 8,
    parameter int CLKS_PER_BIT = 434
) (
    input  logic             i_clk,
    input  logic             i_rest,
    input  logic [WIDTH-1:0] i_data,
    input  logic             i_empty,
    output logic             o_ren,
    output logic             o_tx,
    output logic             o_busy,
    output logic             o_done
);

    localparam int              BW        = $clog2(WIDTH) + 1;
    localparam logic [15:0]     BAUD_LAST = 16'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0]   BIT_LAST  = BW'(WIDTH - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_REQ    = 3'd1,
        S_LOAD   = 3'd2,
        S_START  = 3'd3,
        S_DATA   = 3'd4,
`ifdef UART_TX_PARITY_EN
        S_PARITY = 3'd5,
`endif
        S_STOP   = 3'd6
    } state_t;

    state_t             state_q, state_d;
    logic [15:0]        baud_q, baud_d;
    logic [BW-1:0]      bit_q, bit_d;
    logic [WIDTH-1:0]   shift_q, shift_d;
    logic               tx_q, tx_d;
    logic               ren_q, ren_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               baud_last;
`ifdef UART_TX_PARITY_EN
    logic               par_q, par_d;
`endif

    assign baud_last = (baud_q == BAUD_LAST);

    // Next-state, counters and registered-output values, all derived from the
    // upcoming state so every output is a flop with no input-to-output path.
    always_comb begin
        state_d = state_q;
        baud_d  = baud_q + 16'd1;
        bit_d   = bit_q;
        shift_d = shift_q;
`ifdef UART_TX_PARITY_EN
        par_d   = par_q;
`endif
        case (state_q)
            S_IDLE: begin
                baud_d = '0;
                if (!i_empty) state_d = S_REQ;
            end
            S_REQ:  state_d = S_LOAD;
            S_LOAD: begin
                shift_d = i_data;
`ifdef UART_TX_PARITY_EN
                par_d   = ^i_data;
`endif
                state_d = S_START;
            end
            S_START: begin
                if (baud_last) begin
                    bit_d   = '0;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                if (baud_last) begin
                    baud_d  = '0;
                    shift_d = shift_q >> 1;
                    if (bit_q == BIT_LAST) begin
`ifdef UART_TX_PARITY_EN
                        state_d = S_PARITY;
`else
                        state_d = S_STOP;
`endif
                    end else begin
                        bit_d = bit_q + 1'b1;
                    end
                end
            end
`ifdef UART_TX_PARITY_EN
            S_PARITY: begin
                if (baud_last) state_d = S_STOP;
            end
`endif
            S_STOP: begin
                // Final stop cycle is the only other point where i_empty is looked at.
                if (baud_last) state_d = i_empty ? S_IDLE : S_REQ;
            end
            default: state_d = S_IDLE;
        endcase

        // Every state entry restarts the bit-period count.
        if (state_d != state_q) baud_d = '0;

        ren_d  = (state_d == S_REQ);
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_STOP) && (baud_d == BAUD_LAST);
        case (state_d)
            S_START:  tx_d = 1'b0;
            S_DATA:   tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
            S_PARITY: tx_d = par_d;
`endif
            default:  tx_d = 1'b1;
        endcase
    end

    // State and output registers with synchronous reset; line returns high at once.
    always_ff @(posedge i_clk) begin
        if (i_rest) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
            ren_q   <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef UART_TX_PARITY_EN
            par_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
            ren_q   <= ren_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
`ifdef UART_TX_PARITY_EN
            par_q   <= par_d;
`endif
        end
    end

    assign o_tx   = tx_q;
    assign o_ren  = ren_q;
    assign o_busy = busy_q;
    assign o_done = done_q;

endmodule

`default_nettype wire

// File: tb/tb_fifo_uart_tx.sv
// ============================================================================
// Module   : tb_fifo_uart_tx
// Purpose  : Self-checking bench for fifo_uart_tx with a FIFO model feeding it
//            and a frame monitor comparing serial bits against a scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_uart_tx;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] d_data = 8'h00;
    logic       d_empty = 1'b1;
    logic       o_ren, o_tx, o_busy, o_done;

    int n_vec = 0;
    int n_err = 0;

    logic [7:0] fifo_q[$];
    logic [7:0] sb_q[$];
    int         starts_q[$];

    int         cyc = 0;
    int         ren_cnt = 0;
    int         done_cnt = 0;
    int         t_ren = 0;
    logic       prev_ren = 1'b0;
    logic       mon_act = 1'b0;
    int         mon_off = 0;
    logic [7:0] cur = 8'h00;

    fifo_uart_tx #(.WIDTH(8), .CLKS_PER_BIT(CPB)) u_dut (
        .i_clk   (clk),
        .i_rest  (rst),
        .i_data  (d_data),
        .i_empty (d_empty),
        .o_ren   (o_ren),
        .o_tx    (o_tx),
        .o_busy  (o_busy),
        .o_done  (o_done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at cycle %0d", tag, act, exp, cyc);
        end
    endtask

    function automatic logic exp_bit(input int idx, input logic [7:0] b);
        if (idx == 0)      return 1'b0;
        if (idx <= 8)      return b[idx-1];
`ifdef UART_TX_PARITY_EN
        if (idx == 9)      return ^b;
`endif
        return 1'b1;
    endfunction

    // FIFO model, scoreboard producer and frame monitor, all sampled mid-cycle.
    always @(negedge clk) begin
        cyc++;
        if (o_done) done_cnt++;
        if (o_ren) begin
            chk("ren_single_cycle", prev_ren, 0);
            chk("ren_when_nonempty", fifo_q.size() > 0, 1);
            ren_cnt++;
            t_ren = cyc;
            if (fifo_q.size() > 0) begin
                d_data = fifo_q.pop_front();
                sb_q.push_back(d_data);
            end
        end
        prev_ren = o_ren;
        d_empty  = (fifo_q.size() == 0);

        if (rst) begin
            mon_act = 1'b0;
        end else if (!mon_act) begin
            if (o_tx == 1'b0) begin
                mon_act = 1'b1;
                mon_off = 0;
                starts_q.push_back(cyc);
                chk("ren_to_start", cyc - t_ren, 2);
                if (sb_q.size() == 0) chk("scoreboard_empty", 0, 1);
                else                  cur = sb_q.pop_front();
            end
        end else begin
            mon_off++;
            if (mon_off % CPB == CPB / 2)
                chk($sformatf("tx_bit%0d_byte%02h", mon_off / CPB, cur),
                    o_tx, exp_bit(mon_off / CPB, cur));
            if (mon_off == FRAME - 2) chk("done_early", o_done, 0);
            if (mon_off == FRAME - 1) begin
                chk("done_last_stop", o_done, 1);
                chk("tx_stop_end", o_tx, 1);
                mon_act = 1'b0;
            end
        end
    end

    task automatic wait_done(input int target);
        int b = 0;
        while (done_cnt < target && b < 3000) begin
            @(negedge clk);
            b++;
        end
        chk("done_timeout", done_cnt >= target, 1);
    endtask

    initial begin : stim
        int d0, r0, b, n;
        // Reset and idle line
        repeat (3) @(negedge clk);
        chk("rst_tx", o_tx, 1);
        chk("rst_ren", o_ren, 0);
        chk("rst_busy", o_busy, 0);
        chk("rst_done", o_done, 0);
        rst = 1'b0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            chk("idle_tx", o_tx, 1);
            chk("idle_ren", o_ren, 0);
            chk("idle_busy", o_busy, 0);
        end

        // Single byte, then verify return to idle with empty FIFO
        fifo_q.push_back(8'hA5);
        wait_done(1);
        repeat (5) @(negedge clk);
        chk("single_ren_count", ren_cnt, 1);
        chk("single_idle_busy", o_busy, 0);
        chk("single_idle_tx", o_tx, 1);

        // Parity-sensitive bytes
        fifo_q.push_back(8'h07);
        wait_done(2);
        repeat (3) @(negedge clk);
        fifo_q.push_back(8'h03);
        wait_done(3);
        repeat (5) @(negedge clk);
        chk("parity_ren_count", ren_cnt, 3);

        // Back-to-back
        r0 = ren_cnt;
        fifo_q.push_back(8'h01);
        fifo_q.push_back(8'h02);
        fifo_q.push_back(8'h03);
        wait_done(6);
        repeat (10) @(negedge clk);
        chk("b2b_ren_count", ren_cnt - r0, 3);
        chk("b2b_idle_busy", o_busy, 0);
        n = starts_q.size();
        if (n >= 3) begin
            chk("b2b_spacing_1", starts_q[n-2] - starts_q[n-3], FRAME + 2);
            chk("b2b_spacing_2", starts_q[n-1] - starts_q[n-2], FRAME + 2);
        end else begin
            chk("b2b_start_count", n, 3);
        end

        // Reset during data bit 3
        d0 = done_cnt;
        fifo_q.push_back(8'h5A);
        b = 0;
        do begin
            @(negedge clk);
            b++;
        end while (o_tx !== 1'b0 && b < 500);
        chk("abort_start_seen", o_tx, 0);
        repeat (16) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_tx_high", o_tx, 1);
        chk("abort_busy", o_busy, 0);
        r0 = ren_cnt;
        fifo_q.push_back(8'h3C);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("abort_no_ren_in_reset", o_ren, 0);
        end
        chk("abort_no_done", done_cnt, d0);
        rst = 1'b0;
        wait_done(d0 + 1);
        repeat (5) @(negedge clk);
        chk("abort_ren_after", ren_cnt - r0, 1);
        chk("abort_done_once", done_cnt, d0 + 1);
        chk("scoreboard_drained", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
